// File: rtl/tdm_demux4_pkg.sv
// Shared types and sizes for the receive-side 4-slot TDM demultiplexer.
package tdm_demux4_pkg;
  localparam int NR_SLOT = 4;
  localparam int KEY_LEN = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } state_e;
endpackage

// File: rtl/tdm_slot_dec.sv
// Key to one-hot slot write-enable decoder; mirrors the transmit-side selector.
module tdm_slot_dec
  import tdm_demux4_pkg::*;
(
  input  logic               en_i,
  input  logic [KEY_LEN-1:0] key_i,
  output logic [NR_SLOT-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) we_o[key_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Rebuilds a 4-slot frame from key-tagged beats and hands it off on valid/ready.
// state   | meaning
// IDLE    | waiting for an sof beat on key 0
// COLLECT | slot exp_q is the next one expected
// FULL    | frame held on the output until the consumer takes it
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int DATA_LEN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [KEY_LEN-1:0]          in_key,
  input  logic [DATA_LEN-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NR_SLOT*DATA_LEN-1:0] out_value,
  output logic                        err,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic [CNT_W-1:0]            err_cnt
);

  state_e              state_q;
  logic [KEY_LEN-1:0]  exp_q;
  logic [DATA_LEN-1:0] slot_q [NR_SLOT];
  logic                out_valid_q;
  logic                err_q;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                accept, sof0, in_order, violation, slot_wr_en;
  logic [NR_SLOT-1:0]  slot_we;

  always_comb begin
    accept     = in_valid && in_ready;
    sof0       = in_sof && (in_key == '0);
    in_order   = (state_q == COLLECT) && (in_key == exp_q) && !in_sof;
    // A resync sof is still a violation, but its payload starts the new frame.
    slot_wr_en = accept && (sof0 || in_order);
    violation  = accept && !(((state_q == IDLE) && sof0) || in_order);
    frame_cnt_d = frame_cnt_q + 8'd1;
    err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  tdm_slot_dec u_slot_dec (
    .en_i  (slot_wr_en),
    .key_i (in_key),
    .we_o  (slot_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_SLOT; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR_SLOT; i++) begin
        if (slot_we[i]) slot_q[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_q <= violation;
      if (violation) err_cnt_q <= err_cnt_d;
      case (state_q)
        IDLE: begin
          if (accept && sof0) begin
            exp_q   <= 2'd1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (in_order) begin
              if (exp_q == 2'd3) begin
                exp_q       <= '0;
                out_valid_q <= 1'b1;
                state_q     <= FULL;
              end else begin
                exp_q <= exp_q + 2'd1;
              end
            end else if (sof0) begin
              exp_q <= 2'd1;
            end else begin
              exp_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          exp_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NR_SLOT; g++) begin : g_out
    assign out_value[g*DATA_LEN +: DATA_LEN] = slot_q[g];
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and random beats against a frame-list model of the 4-slot demux.
module tb_tdm_demux4;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [1:0]    in_key = '0;
  logic [DL-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4*DL-1:0] out_value;
  logic          err;
  logic [7:0]    frame_cnt;
  logic [7:0]    err_cnt;

  tdm_demux4 #(.DATA_LEN(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .err       (err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the partial frame is a list of payloads; its length is the next slot.
  int          m_frame[$];
  bit          m_full;
  logic [15:0] m_out;
  bit          m_err;
  int          m_fcnt;
  int          m_ecnt;

  task automatic model_clear();
    m_frame.delete();
    m_full = 0;
    m_out  = '0;
    m_err  = 0;
    m_fcnt = 0;
    m_ecnt = 0;
  endtask

  task automatic step();
    bit sof0;
    @(posedge clk);
    m_err = 0;
    if (m_full) begin
      if (out_ready) begin
        m_full = 0;
        m_fcnt = (m_fcnt + 1) % 256;
      end
    end else if (in_valid) begin
      sof0 = in_sof && (in_key == 2'd0);
      if (m_frame.size() == 0) begin
        if (sof0) m_frame.push_back(int'(in_data));
        else m_err = 1;
      end else if (!in_sof && int'(in_key) == m_frame.size()) begin
        m_frame.push_back(int'(in_data));
        if (m_frame.size() == 4) begin
          m_full = 1;
          m_out  = '0;
          for (int i = 0; i < 4; i++) m_out = m_out | (16'(m_frame[i]) << (4 * i));
          m_frame.delete();
        end
      end else begin
        m_err = 1;
        m_frame.delete();
        if (sof0) m_frame.push_back(int'(in_data));
      end
    end
    if (m_err && m_ecnt < 255) m_ecnt++;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("in_ready", 32'(in_ready), 32'(!m_full));
    chk("err", 32'(err), 32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
    if (m_full) chk("out_value", 32'(out_value), 32'(m_out));
  endtask

  task automatic beat(input bit v, input bit s, input int k, input int d, input bit ordy);
    in_valid  = v;
    in_sof    = s;
    in_key    = 2'(k);
    in_data   = DL'(d);
    out_ready = ordy;
    step();
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    in_valid  = 0;
    out_ready = 0;
    #3 rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_out_value", 32'(out_value), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    model_clear();
  endtask

  initial begin
    int k;
    bit s;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // clean frame
    beat(1, 1, 0, 'hA, 1);
    beat(1, 0, 1, 'hB, 1);
    beat(1, 0, 2, 'hC, 1);
    beat(1, 0, 3, 'hD, 1);
    chk("clean_value", 32'(out_value), 32'h0000_DCBA);
    beat(0, 0, 0, 0, 1);
    chk("clean_fcnt", 32'(frame_cnt), 32'd1);

    // backpressure with in_valid held high
    beat(1, 1, 0, 1, 0);
    beat(1, 0, 1, 2, 0);
    beat(1, 0, 2, 3, 0);
    beat(1, 0, 3, 4, 0);
    for (int i = 0; i < 10; i++) begin
      beat(1, 1, 0, 5, 0);
      chk("bp_value", 32'(out_value), 32'h0000_4321);
    end
    beat(1, 1, 0, 5, 1);
    chk("bp_release", 32'(in_ready), 32'd1);
    beat(0, 0, 0, 0, 0);

    // order error, then non-sof beat in IDLE
    beat(1, 1, 0, 1, 1);
    beat(1, 0, 1, 2, 1);
    beat(1, 0, 3, 3, 1);
    chk("ord_err", 32'(err), 32'd1);
    chk("ord_ecnt", 32'(err_cnt), 32'd1);
    beat(1, 0, 2, 4, 1);
    chk("ord_err2", 32'(err_cnt), 32'd2);

    // resync mid-frame
    beat(1, 1, 0, 9, 1);
    beat(1, 0, 1, 9, 1);
    beat(1, 1, 0, 1, 1);
    chk("resync_err", 32'(err), 32'd1);
    beat(1, 0, 1, 2, 1);
    beat(1, 0, 2, 3, 1);
    beat(1, 0, 3, 4, 1);
    chk("resync_value", 32'(out_value), 32'h0000_4321);
    beat(0, 0, 0, 0, 1);

    // reset mid-frame, then a normal frame
    beat(1, 1, 0, 7, 1);
    beat(1, 0, 1, 8, 1);
    beat(1, 0, 2, 9, 1);
    do_reset();
    beat(1, 1, 0, 6, 1);
    beat(1, 0, 1, 5, 1);
    beat(1, 0, 2, 4, 1);
    beat(1, 0, 3, 3, 1);
    chk("post_rst_value", 32'(out_value), 32'h0000_3456);
    beat(0, 0, 0, 0, 1);
    chk("post_rst_fcnt", 32'(frame_cnt), 32'd1);

    // counter wrap and saturation
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int j = 0; j < 4; j++) beat(1, j == 0, j, (f + j) % 16, 1);
      beat(0, 0, 0, 0, 1);
    end
    chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
    for (int e = 0; e < 260; e++) beat(1, 0, 1, 0, 1);
    chk("ecnt_sat", 32'(err_cnt), 32'd255);

    // randomized traffic, mostly in order
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(9) < 8) k = m_frame.size() % 4;
      else k = int'($urandom_range(3));
      if (k == 0) s = ($urandom_range(3) != 0);
      else s = ($urandom_range(9) == 0);
      beat($urandom_range(3) != 0, s, k, int'($urandom_range(15)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side time-division demultiplexer, the far end of a 4-way key-selected mux link: the transmitter drives one slot per beat, tagged with a 2-bit key. This block rebuilds the 4-slot frame by steering each beat into the register its key selects. It checks slot order, and presents the assembled frame on a valid/ready output. It sits between the serial slot link and any parallel consumer, such as the seven-segment or LED logic.

## Interface
- DATA_LEN, 1, width of one slot's payload
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present on in_key/in_data/in_sof
- in_ready  out  1  block accepts beat this cycle
- in_sof  in  1  start-of-frame marker, legal only with in_key==2'b00
- in_key  in  2  slot index of beat
- in_data  in  DATA_LEN  slot payload
- out_valid  out  1  complete frame available
- out_ready  in  1  consumer takes frame
- out_value  out  4*DATA_LEN  slot i at [i*DATA_LEN +: DATA_LEN]
- err  out  1  one-cycle pulse on protocol violation
- frame_cnt  out  8  frames delivered, wraps 255->0
- err_cnt  out  8  violations seen, saturates at 255

## Operation
- Beat accepted when in_valid & in_ready.
- States:
  - IDLE: wait for a frame start.
  - COLLECT: the next expected slot exp is held in a 2-bit register.
  - FULL: hold the frame until the consumer takes it.
- IDLE:
  - Accepted beat with in_sof=1, key=0: write slot 0, exp<=1, go to COLLECT.
  - Any other accepted beat: err, stay in IDLE.
- COLLECT, accepted beat with key==exp and in_sof=0: write slot exp.
  - exp<3: exp<=exp+1, stay in COLLECT.
  - exp==3: go to FULL.
- COLLECT, accepted beat with key!=exp or in_sof=1: err, and the partial frame is dropped.
  - Beat has in_sof=1 and key=0: it resyncs. Write slot 0, exp<=1, stay in COLLECT.
  - Otherwise: go to IDLE.
- FULL: out_valid=1 and in_ready=0. When out_ready=1, frame_cnt++ and go to IDLE.
- in_ready = (state!=FULL).
- Slot registers are written only on an accepted, in-order beat. Slots of a dropped frame keep their stale data, but out_value is only meaningful while out_valid=1.
- err_cnt increments on every err pulse and saturates at 255. frame_cnt wraps.
- out_value, out_valid, frame_cnt and err_cnt are registered outputs, never combinational from inputs.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, exp=0.
  - All slot registers, out_value, out_valid, err, frame_cnt and err_cnt are 0.
  - in_ready=1.
- Latency: slot-3 beat accepted at edge N gives out_valid=1 from after edge N, i.e. visible in cycle N+1.
- out_valid stays high, with out_value stable, until the edge where out_ready=1. It deasserts after that edge.
- Minimum frame period is 5 cycles: 4 beats plus 1 handoff cycle. There is no input/output overlap in FULL.
- err is high for exactly the cycle following the offending accept.
- Reset asserted mid-frame or in FULL: outputs clear immediately, the frame is lost, and frame_cnt is not incremented.
- out_ready while out_valid=0 is ignored. in_data/in_key while in_valid=0 or in_ready=0 are ignored.

## Structure
- Shared package:
  - NR_SLOT=4, KEY_LEN=2.
  - State enum {IDLE, COLLECT, FULL}.
  - CNT_W=8.
- Sub-module: tdm_slot_dec, a combinational 2-bit key to 4-bit one-hot write-enable decoder gated by the accept and in-order condition. It mirrors the transmit-side selector.

## Test plan
- Clean frame, DATA_LEN=4:
  - Stimulus: beats (sof,0,0xA),(1,0xB),(2,0xC),(3,0xD) back-to-back, out_ready=1.
  - Response: out_valid one cycle after 4th accept, out_value=0xDCBA. frame_cnt=1, in_ready low exactly 1 cycle, err never.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after frame completes, with in_valid held high.
  - Response: in_ready=0 and out_value stable throughout. The frame is consumed on the first out_ready=1, then in_ready=1.
- Order error:
  - Stimulus: keys 0(sof),1,3.
  - Response: err pulse after key-3 accept, err_cnt=1, state IDLE. A following non-sof key-2 beat gives a 2nd err.
- Resync:
  - Stimulus: keys 0(sof),1, then 0(sof),1,2,3 with data 1..4 on the second frame.
  - Response: one err, then out_value=0x4321 (DATA_LEN=4), frame_cnt=1.
- Reset mid-frame:
  - Stimulus: after keys 0,1,2 accepted, pulse rst_n low mid-cycle.
  - Response: all outputs 0 immediately, no out_valid. The next full frame is delivered normally.
- Counters:
  - Stimulus: 256 good frames, then 260 errors.
  - Response: frame_cnt=0 after the wrap, err_cnt=255 saturated.
